// File: rtl/onepole_pkg.sv
// Shared types and width helpers for the multichannel one-pole filter.
package onepole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_e;

    localparam logic LP = 1'b0;
    localparam logic HP = 1'b1;

    // Widths for the default build; parameterised instances use the functions below.
    localparam int DIFF_W = 16 + 1;
    localparam int PROD_W = DIFF_W + 8 + 1;

    function automatic int diff_w(input int bitsize);
        return bitsize + 1;
    endfunction

    function automatic int prod_w(input int bitsize, input int alpha_bits);
        return diff_w(bitsize) + alpha_bits + 1;
    endfunction

endpackage

// File: rtl/onepole_narrow.sv
// Narrows a BITSIZE+2 signed value to BITSIZE bits: two's-complement wrap by default,
// clamping to the signed range when ONEPOLE_SATURATE_EN is defined.
module onepole_narrow #(
    parameter int BITSIZE = 16
) (
    input  logic signed [BITSIZE+1:0] in_i,
    output logic signed [BITSIZE-1:0] out_o
);

`ifdef ONEPOLE_SATURATE_EN
    localparam logic signed [BITSIZE+1:0] MAX_V = {3'b000, {(BITSIZE-1){1'b1}}};
    localparam logic signed [BITSIZE+1:0] MIN_V = {3'b111, {(BITSIZE-1){1'b0}}};

    always_comb begin
        out_o = in_i[BITSIZE-1:0];
        if (in_i > MAX_V) begin
            out_o = MAX_V[BITSIZE-1:0];
        end else if (in_i < MIN_V) begin
            out_o = MIN_V[BITSIZE-1:0];
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^in_i[BITSIZE+1:BITSIZE];
    assign out_o     = in_i[BITSIZE-1:0];
`endif

endmodule

// File: rtl/multichannel_onepole_filter.sv
// Time-multiplexed one-pole IIR (LP or complementary HP), one shared multiplier.
// Build option ONEPOLE_SATURATE_EN selects saturating instead of wrapping narrowing.
//
// state | meaning
// IDLE  | in_ready high; accept a frame, or zero all channel states on clear
// MUL   | diff = x[ch] - y[ch], register diff * alpha
// ACC   | y[ch] += prod >>> ALPHA_BITS, write output lane, advance or finish
module multichannel_onepole_filter
    import onepole_pkg::*;
#(
    parameter int BITSIZE    = 16,
    parameter int CHANNELS   = 4,
    parameter int ALPHA_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*BITSIZE-1:0]  in_data,
    input  logic [ALPHA_BITS-1:0]        alpha,
    input  logic                         mode,
    input  logic                         clear,
    output logic                         out_valid,
    output logic [CHANNELS*BITSIZE-1:0]  out_data
);

    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int D_W    = diff_w(BITSIZE);
    localparam int P_W    = prod_w(BITSIZE, ALPHA_BITS);
    localparam int ACC_W  = BITSIZE + 2;

    state_e                       state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [CHANNELS*BITSIZE-1:0]  x_q;
    logic [ALPHA_BITS-1:0]        alpha_q;
    logic                         mode_q;
    logic signed [BITSIZE-1:0]    y_q [CHANNELS];
    logic signed [P_W-1:0]        prod_q;
    logic [CHANNELS*BITSIZE-1:0]  out_data_q;
    logic                         out_valid_q;

    logic                         accept, do_clear, do_acc, last;
    logic signed [BITSIZE-1:0]    x_cur, y_cur;
    logic signed [D_W-1:0]        diff;
    logic signed [P_W-1:0]        prod_d, p_full;
    logic signed [ACC_W-1:0]      y_new, hp_val, lane_val;
    logic signed [BITSIZE-1:0]    y_narrow, lane_narrow;
    logic                         unused_p;

    assign x_cur    = x_q[int'(ch_q)*BITSIZE +: BITSIZE];
    assign y_cur    = y_q[ch_q];
    assign diff     = {x_cur[BITSIZE-1], x_cur} - {y_cur[BITSIZE-1], y_cur};
    assign prod_d   = diff * $signed({1'b0, alpha_q});
    // Arithmetic shift floors, so negative steps round away from zero.
    assign p_full   = prod_q >>> ALPHA_BITS;
    assign unused_p = ^p_full[P_W-1:ACC_W];
    assign y_new    = {{2{y_cur[BITSIZE-1]}}, y_cur} + p_full[ACC_W-1:0];
    assign hp_val   = {{2{x_cur[BITSIZE-1]}}, x_cur} - y_new;
    assign lane_val = (mode_q == HP) ? hp_val : y_new;

    onepole_narrow #(.BITSIZE(BITSIZE)) u_narrow_state (
        .in_i  (y_new),
        .out_o (y_narrow)
    );

    onepole_narrow #(.BITSIZE(BITSIZE)) u_narrow_lane (
        .in_i  (lane_val),
        .out_o (lane_narrow)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        accept   = 1'b0;
        do_clear = 1'b0;
        do_acc   = 1'b0;
        last     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    ch_d    = '0;
                    state_d = MUL;
                end else if (clear) begin
                    do_clear = 1'b1;
                end
            end
            MUL: state_d = ACC;
            ACC: begin
                do_acc = 1'b1;
                if (ch_q == CH_W'(CHANNELS - 1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = MUL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            x_q         <= '0;
            alpha_q     <= '0;
            mode_q      <= LP;
            prod_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) y_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_valid_q <= last;
            if (accept) begin
                x_q     <= in_data;
                alpha_q <= alpha;
                mode_q  <= mode;
            end
            if (state_q == MUL) prod_q <= prod_d;
            if (do_clear) begin
                for (int i = 0; i < CHANNELS; i++) y_q[i] <= '0;
            end
            if (do_acc) begin
                y_q[ch_q]                                <= y_narrow;
                out_data_q[int'(ch_q)*BITSIZE +: BITSIZE] <= lane_narrow;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_multichannel_onepole_filter.sv
// Randomised and directed bench for multichannel_onepole_filter against an integer reference model.
module tb_multichannel_onepole_filter;

    localparam int B = 16;
    localparam int C = 4;
    localparam int A = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [C*B-1:0]   in_data;
    logic [A-1:0]     alpha;
    logic             mode;
    logic             clear;
    logic             out_valid;
    logic [C*B-1:0]   out_data;

    int n_tests = 0;
    int n_fail  = 0;
    int y_m [C];
    int exp_lane [C];
    int xs [C];

    multichannel_onepole_filter #(.BITSIZE(B), .CHANNELS(C), .ALPHA_BITS(A)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .alpha     (alpha),
        .mode      (mode),
        .clear     (clear),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int narrow(input int v);
`ifdef ONEPOLE_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        int w;
        w = v & 32'hFFFF;
        if (w >= 32768) w = w - 65536;
        return w;
`endif
    endfunction

    function automatic int floor_div(input longint num, input longint den);
        if (num >= 0) return int'(num / den);
        return -int'((-num + den - 1) / den);
    endfunction

    task automatic model_frame(input int a, input bit m);
        for (int ch = 0; ch < C; ch++) begin
            int yn;
            yn = y_m[ch] + floor_div(longint'(xs[ch] - y_m[ch]) * a, 256);
            y_m[ch] = narrow(yn);
            exp_lane[ch] = m ? narrow(xs[ch] - yn) : y_m[ch];
        end
    endtask

    function automatic longint lane(input int ch);
        logic signed [B-1:0] v;
        v = out_data[ch*B +: B];
        return longint'(v);
    endfunction

    task automatic drive(input int a, input bit m);
        for (int ch = 0; ch < C; ch++) in_data[ch*B +: B] = B'(xs[ch]);
        alpha = A'(a);
        mode  = m;
    endtask

    task automatic check_lanes(input string tag);
        for (int ch = 0; ch < C; ch++)
            check($sformatf("%s lane%0d", tag, ch), lane(ch), exp_lane[ch]);
    endtask

    task automatic send_frame(input int a, input bit m, input bit clr_busy, input string tag);
        int w;
        int cnt;
        bit busy_ok;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check({tag, " ready timeout"}, 0, 1);
        drive(a, m);
        in_valid = 1'b1;
        @(posedge clk);
        model_frame(a, m);
        #1 in_valid = 1'b0;
        cnt = 0;
        busy_ok = 1'b1;
        while (!out_valid && cnt < 40) begin
            if (in_ready) busy_ok = 1'b0;
            clear = (clr_busy && cnt == 3);
            @(posedge clk);
            #1 cnt++;
        end
        clear = 1'b0;
        check({tag, " latency"}, cnt, 8);
        check({tag, " busy"}, busy_ok, 1);
        check({tag, " ready at valid"}, in_ready, 1);
        check_lanes(tag);
        @(posedge clk);
        #1 check({tag, " valid pulse"}, out_valid, 0);
    endtask

    initial begin
        int step_lp [4];
        int step_neg [4];
        int step_hp [4];
        int nacc, last_acc, cyc, nvalid;
        bit pending, drop;
        int frozen [C];

        step_lp  = '{500, 750, 875, 937};
        step_neg = '{-500, -750, -875, -938};
        step_hp  = '{500, 250, 125, 63};

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        alpha = '0;
        mode = 1'b0;
        clear = 1'b0;
        for (int ch = 0; ch < C; ch++) y_m[ch] = 0;
        #23;
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset out_data", longint'(out_data), 0);
        @(negedge clk) reset = 1'b0;

        xs = '{1000, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            send_frame(128, 1'b0, 1'b0, "step");
            check($sformatf("step const %0d", i), lane(0), step_lp[i]);
        end

        xs = '{0, -1000, 0, 0};
        for (int i = 0; i < 4; i++) begin
            send_frame(128, 1'b0, 1'b0, "neg");
            check($sformatf("neg const %0d", i), lane(1), step_neg[i]);
        end

        xs = '{0, 0, 1000, 0};
        for (int i = 0; i < 4; i++) begin
            send_frame(128, 1'b1, 1'b0, "hp");
            check($sformatf("hp const %0d", i), lane(2), step_hp[i]);
        end

        xs = '{0, 0, 0, -32768};
        send_frame(255, 1'b0, 1'b0, "ovf pre");
        send_frame(255, 1'b0, 1'b0, "ovf pre");
        check("ovf state min", lane(3), -32768);
        xs = '{0, 0, 0, 32767};
        send_frame(1, 1'b1, 1'b0, "ovf hp");
`ifdef ONEPOLE_SATURATE_EN
        check("ovf hp const", lane(3), 32767);
`else
        check("ovf hp const", lane(3), -256);
`endif

        for (int ch = 0; ch < C; ch++) xs[ch] = int'($urandom_range(0, 65535)) - 32768;
        nacc = 0;
        last_acc = -1;
        cyc = 0;
        pending = 1'b0;
        drop = 1'b0;
        @(negedge clk);
        drive(77, 1'b0);
        in_valid = 1'b1;
        while (cyc < 100 && !(nacc >= 4 && !pending)) begin
            if (out_valid && pending) begin
                check_lanes("b2b");
                pending = 1'b0;
            end
            if (in_ready && nacc < 4) begin
                if (last_acc >= 0) check("b2b gap", cyc - last_acc, 9);
                last_acc = cyc;
                model_frame(77, 1'b0);
                pending = 1'b1;
                nacc++;
                drop = (nacc == 4);
            end
            @(posedge clk);
            if (drop) begin
                #1 in_valid = 1'b0;
                drop = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b done", nacc * 10 + int'(pending), 40);

        for (int ch = 0; ch < C; ch++) xs[ch] = int'($urandom_range(0, 65535)) - 32768;
        @(negedge clk);
        drive(200, 1'b1);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        check("midreset out_data", longint'(out_data), 0);
        check("midreset out_valid", out_valid, 0);
        check("midreset in_ready", in_ready, 1);
        @(negedge clk) reset = 1'b0;
        for (int ch = 0; ch < C; ch++) y_m[ch] = 0;
        nvalid = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) nvalid++;
        end
        check("midreset no valid", nvalid, 0);
        xs = '{1000, 0, 0, 0};
        send_frame(128, 1'b0, 1'b0, "post reset");
        check("post reset const", lane(0), 500);

        for (int i = 0; i < 4; i++) send_frame(255, 1'b0, 1'b0, "settle");
        @(negedge clk) clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        for (int ch = 0; ch < C; ch++) y_m[ch] = 0;
        xs = '{0, 0, 0, 0};
        send_frame(128, 1'b0, 1'b0, "after clear");
        check("after clear const", lane(0), 0);
        xs = '{1000, 0, 0, 0};
        send_frame(128, 1'b0, 1'b1, "busy clear");
        send_frame(128, 1'b0, 1'b0, "busy clear next");
        check("busy clear const", lane(0), 750);

        for (int i = 0; i < 20; i++) begin
            for (int ch = 0; ch < C; ch++) xs[ch] = int'($urandom_range(0, 65535)) - 32768;
            send_frame(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        for (int ch = 0; ch < C; ch++) begin
            frozen[ch] = y_m[ch];
            xs[ch] = int'($urandom_range(0, 65535)) - 32768;
        end
        send_frame(0, 1'b0, 1'b0, "alpha0");
        for (int ch = 0; ch < C; ch++) check($sformatf("alpha0 frozen %0d", ch), lane(ch), frozen[ch]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multichannel_onepole_filter.md
Name: multichannel_onepole_filter

Overview:
- Parametrised, time-multiplexed one-pole IIR filter for the audio path: CHANNELS independent channels share one multiplier.
- Each channel holds its own filter state.
- Per-frame mode select: low-pass output y, or complementary high-pass output (in − y).
- Frame-level valid/ready handshake. Sits between the audio sample source and the mixer/codec output stage.

Parameters:
- BITSIZE, 16, signed sample width per channel.
- CHANNELS, 4, number of channels, ≥1; channel index width is clog2(CHANNELS), min 1.
- ALPHA_BITS, 8, unsigned coefficient width; alpha/2^ALPHA_BITS is the gain, so max usable gain is (2^ALPHA_BITS−1)/2^ALPHA_BITS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  frame present on in_data.
- in_ready  out  1  block can accept a frame.
- in_data  in  CHANNELS*BITSIZE  signed samples; channel n at [n*BITSIZE +: BITSIZE].
- alpha  in  ALPHA_BITS  unsigned coefficient, sampled at frame accept.
- mode  in  1  0 = low-pass, 1 = high-pass; sampled at frame accept.
- clear  in  1  zero all channel states; honoured only in IDLE.
- out_valid  out  1  one-cycle pulse, out_data updated.
- out_data  out  CHANNELS*BITSIZE  filtered samples, same lane packing as in_data.

Behaviour:
- Reset (async):
  - FSM goes to IDLE.
  - All channel states = 0, out_data = 0, out_valid = 0, in_ready = 1.
  - Reset asserted mid-frame aborts the frame; the partial result is discarded.
- Handshake:
  - Frame accepted on a rising edge with in_valid & in_ready.
  - in_data, alpha and mode are latched on that edge.
  - in_ready = 1 only in IDLE; in_valid while busy is ignored (no queuing).
- FSM states:
  - IDLE: accept a frame → MUL, ch = 0. Otherwise, if clear, zero all states.
  - MUL (ch): diff = x[ch] − y[ch], BITSIZE+1 signed. prod = diff * {1'b0, alpha}, registered. → ACC.
  - ACC (ch): p = prod >>> ALPHA_BITS (arithmetic, floor). y_new = y[ch] + p, BITSIZE+2 signed, then narrowed. Write y[ch] = y_new.
    - Output lane = y_new (mode 0) or x[ch] − y_new (mode 1), then narrowed.
    - If ch == CHANNELS−1 → IDLE and set out_valid for the next cycle. Else ch+1 → MUL.
- Narrowing rule without the optional feature: two's-complement wrap (low BITSIZE bits).
- Latency:
  - A frame accepted at edge k produces out_valid high during the cycle after edge k+2*CHANNELS.
  - Throughput: one frame per 2*CHANNELS+1 cycles.
  - in_ready is high during the out_valid cycle, so back-to-back frames are legal.
- out_data lanes update as each ACC completes; they are only guaranteed coherent while out_valid = 1, and held until the next frame's writes.
- Arithmetic edge cases:
  - alpha = 0 → state frozen.
  - Floor rounding biases negative: the LP state can reach −2^(BITSIZE−1) exactly.
  - LP y_new always lies between y and x, so LP never overflows; the HP path can.
- clear and in_valid asserted together in IDLE: the frame is accepted and clear is ignored.

Optional Feature:
- Macro ONEPOLE_SATURATE_EN.
- Defined: every narrowing (state write and output lane) saturates to [−2^(BITSIZE−1), 2^(BITSIZE−1)−1].
- Undefined: wrap, as above.

Decomposition:
- Package onepole_pkg holds:
  - FSM state enum (IDLE, MUL, ACC);
  - mode constants LP = 0, HP = 1;
  - width helper constants DIFF_W = BITSIZE+1 and PROD_W = DIFF_W+ALPHA_BITS+1.
- Sub-module onepole_narrow: combinational BITSIZE+2 → BITSIZE narrowing (wrap or saturate under the macro), instanced twice.

Test Plan (BITSIZE=16, CHANNELS=4, ALPHA_BITS=8):
- Step response: after reset, alpha=128, mode LP, ch0 = 1000, other lanes 0, four frames → ch0 outputs 500, 750, 875, 937; other lanes stay 0; each out_valid arrives exactly 8 cycles after its accept edge.
- Negative step and rounding: ch1 = −1000, alpha=128 → −500, −750, −875, −938.
- High-pass: ch2 = 1000, alpha=128, mode HP → outputs 500, 250, 125, 63.
- Overflow:
  - First drive ch3 = −32768, alpha=255, LP until the state equals −32768.
  - Then one frame with mode HP, alpha=1, ch3 = 32767 → lane 32767 with ONEPOLE_SATURATE_EN, −256 without.
- Handshake and reset:
  - in_valid held high continuously → accepts exactly every 9 cycles; in_ready = 0 for cycles 1–8 after each accept.
  - Async reset pulse during the 3rd channel's MUL → out_data = 0, no out_valid, states zero, next frame behaves as from reset.
- Clear: settle ch0 at 1000, pulse clear in IDLE, then frame ch0 = 0 with alpha=128 → output 0. clear pulsed while busy → no effect.
